// File: rtl/ps2_pkg.sv
// Shared types and byte codes for the PS/2 keyboard front end.
// Build option: PS2_PARITY_CHECK_EN (consumed in ps2_frame_rx).
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  localparam logic [7:0] PFX_EXT    = 8'hE0;
  localparam logic [7:0] PFX_REL    = 8'hF0;
  localparam logic [7:0] PFX_PAUSE  = 8'hE1;

  // Overrun markers and controller replies: never key events.
  localparam logic [7:0] CODE_OVR0  = 8'h00;
  localparam logic [7:0] CODE_OVR1  = 8'hFF;
  localparam logic [7:0] RPL_BAT    = 8'hAA;
  localparam logic [7:0] RPL_ACK    = 8'hFA;
  localparam logic [7:0] RPL_ECHO   = 8'hEE;
  localparam logic [7:0] RPL_RESEND = 8'hFE;

  // Shift codes the keyboard injects around extended keys.
  localparam logic [7:0] KEY_FAKE_LSH = 8'h12;
  localparam logic [7:0] KEY_FAKE_RSH = 8'h59;

  // Bytes of the Pause sequence following its leading E1.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  function automatic logic is_reply_code(input logic [7:0] b);
    return (b == CODE_OVR0) || (b == CODE_OVR1) || (b == RPL_BAT) ||
           (b == RPL_ACK)   || (b == RPL_ECHO)  || (b == RPL_RESEND);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizer, clock glitch filter, 11-bit frame FSM
// and inter-edge timeout. Emits one byte_vld pulse per accepted byte.
// Build option: PS2_PARITY_CHECK_EN rejects frames whose {data, parity}
// has even parity; otherwise the parity bit is latched but not enforced.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       byte_vld,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       timeout
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam logic PAR_CHECK = 1'b1;
`else
  localparam logic PAR_CHECK = 1'b0;
`endif

  logic [1:0]    clk_sync, data_sync;
  logic          clk_filt, clk_filt_q;
  logic [FW-1:0] filt_cnt;
  logic          fall, data_bit;

  frame_state_t  state, state_n;
  logic [2:0]    bitcnt, bitcnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bit, par_n;
  logic [TW-1:0] timer, timer_n;
  logic          vld_n, err_n, tmo_n;
  logic          parity_good, accept;

  // Two-flop synchronizers; lines idle high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
    end
  end

  // Filtered clock flips after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt   <= 1'b1;
      clk_filt_q <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_filt_q <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall        = clk_filt_q & ~clk_filt;
  assign data_bit    = data_sync[1];
  assign parity_good = ^{shreg, par_bit};
  assign accept      = data_bit & (parity_good | ~PAR_CHECK);
  assign rx_byte     = shreg;

  // Frame state and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      timer     <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      bitcnt    <= bitcnt_n;
      shreg     <= shreg_n;
      par_bit   <= par_n;
      timer     <= timer_n;
      byte_vld  <= vld_n;
      frame_err <= err_n;
      timeout   <= tmo_n;
    end
  end

  // Next-state, shift and timeout logic; a fall beats a same-cycle timeout.
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    par_n    = par_bit;
    timer_n  = timer;
    vld_n    = 1'b0;
    err_n    = 1'b0;
    tmo_n    = 1'b0;

    if (state != IDLE) timer_n = timer + TW'(1);
    if (fall)          timer_n = '0;

    case (state)
      IDLE: begin
        if (fall && !data_bit) begin
          state_n  = DATA;
          bitcnt_n = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shreg_n  = {data_bit, shreg[7:1]};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_n   = data_bit;
          state_n = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          if (accept) vld_n = 1'b1;
          else        err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (!fall && (state != IDLE) && (timer == TW'(TIMEOUT_CYC - 1))) begin
      state_n = IDLE;
      timer_n = '0;
      err_n   = 1'b1;
      tmo_n   = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder top: strips E0/F0/E1 prefixes and drops controller
// replies, publishing {toggle, release, extended, code} on ps2_key.
// Build option: PS2_PARITY_CHECK_EN (passed through to ps2_frame_rx).
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  logic       byte_vld, timeout;
  logic [7:0] rx_byte;
  logic       ext, rel;
  logic [2:0] skip;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .byte_vld   (byte_vld),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err),
    .timeout    (timeout)
  );

  // Prefix flags, Pause swallowing and the published key event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext     <= 1'b0;
      rel     <= 1'b0;
      skip    <= '0;
      ps2_key <= '0;
    end else if (timeout) begin
      ext <= 1'b0;
      rel <= 1'b0;
    end else if (byte_vld) begin
      if (skip != 3'd0) begin
        skip <= skip - 3'd1;
      end else if (rx_byte == PFX_EXT) begin
        ext <= 1'b1;
      end else if (rx_byte == PFX_REL) begin
        rel <= 1'b1;
      end else if (rx_byte == PFX_PAUSE) begin
        skip <= PAUSE_SKIP;
      end else if (is_reply_code(rx_byte) ||
                   (ext && (rx_byte == KEY_FAKE_LSH || rx_byte == KEY_FAKE_RSH))) begin
        ext <= 1'b0;
        rel <= 1'b0;
      end else begin
        ps2_key <= {~ps2_key[10], rel, ext, rx_byte};
        ext     <= 1'b0;
        rel     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: table of single-frame vectors plus
// hand-written timeout, parity, stop-bit and mid-frame reset sequences.
// Expectations under PS2_PARITY_CHECK_EN follow the same macro.
module tb_ps2_key_decoder;

  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 2000;
  localparam int HALF        = 40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_data_in = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int tog_cnt = 0;
  logic tog_prev = 1'b0;

  ps2_key_decoder #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_key    (ps2_key),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Count frame_err pulses and toggle-bit edges away from the active edge.
  always @(negedge clk) begin
    if (reset_n && frame_err) err_cnt <= err_cnt + 1;
    if (ps2_key[10] !== tog_prev) tog_cnt <= tog_cnt + 1;
    tog_prev <= ps2_key[10];
  end

  typedef struct {
    logic [7:0]  code;
    logic [10:0] exp_key;
    int          exp_tog;
  } vec_t;

  vec_t vecs[19];

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data_in = b;
    wait_clk(HALF);
    ps2_clk_in = 1'b0;
    wait_clk(HALF);
    ps2_clk_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par,
                            input bit bad_stop, input int nbits);
    logic [10:0] frm;
    frm = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(frm[i]);
    ps2_data_in = 1'b1;
    wait_clk(3 * HALF);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int e0, t0;
  logic [10:0] key_exp;

  initial begin
    vecs[0]  = '{8'h1C, 11'h41C, 1};
    vecs[1]  = '{8'hF0, 11'h41C, 0};
    vecs[2]  = '{8'h1C, 11'h21C, 1};
    vecs[3]  = '{8'hE0, 11'h21C, 0};
    vecs[4]  = '{8'hF0, 11'h21C, 0};
    vecs[5]  = '{8'h75, 11'h775, 1};
    vecs[6]  = '{8'hE1, 11'h775, 0};
    vecs[7]  = '{8'h14, 11'h775, 0};
    vecs[8]  = '{8'h77, 11'h775, 0};
    vecs[9]  = '{8'hE1, 11'h775, 0};
    vecs[10] = '{8'hF0, 11'h775, 0};
    vecs[11] = '{8'h14, 11'h775, 0};
    vecs[12] = '{8'hF0, 11'h775, 0};
    vecs[13] = '{8'h77, 11'h775, 0};
    vecs[14] = '{8'h29, 11'h029, 1};
    vecs[15] = '{8'hAA, 11'h029, 0};
    vecs[16] = '{8'hE0, 11'h029, 0};
    vecs[17] = '{8'h12, 11'h029, 0};
    vecs[18] = '{8'h1C, 11'h41C, 1};

    wait_clk(5);
    reset_n = 1'b1;
    wait_clk(5);
    check("reset_key", int'(ps2_key), 0);
    check("reset_err", int'(frame_err), 0);

    for (int i = 0; i < 19; i++) begin
      e0 = err_cnt;
      t0 = tog_cnt;
      send_frame(vecs[i].code, 1'b0, 1'b0, 11);
      check($sformatf("vec%0d_key", i), int'(ps2_key), int'(vecs[i].exp_key));
      check($sformatf("vec%0d_tog", i), tog_cnt - t0, vecs[i].exp_tog);
      check($sformatf("vec%0d_err", i), err_cnt - e0, 0);
    end

    // Clock pulse with data high while idle: ignored, no error.
    e0 = err_cnt;
    send_frame(8'hFF, 1'b0, 1'b0, 0);
    ps2_bit(1'b1);
    wait_clk(3 * HALF);
    check("idle_high_err", err_cnt - e0, 0);

    // E0 then a frame stalled after 5 bits: one timeout, flags cleared.
    send_frame(8'hE0, 1'b0, 1'b0, 11);
    e0 = err_cnt;
    t0 = tog_cnt;
    send_frame(8'h16, 1'b0, 1'b0, 5);
    wait_clk(2 * TIMEOUT_CYC);
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_tog", tog_cnt - t0, 0);
    e0 = err_cnt;
    t0 = tog_cnt;
    send_frame(8'h16, 1'b0, 1'b0, 11);
    check("after_to_key", int'(ps2_key), 11'h016);
    check("after_to_tog", tog_cnt - t0, 1);
    check("after_to_err", err_cnt - e0, 0);

    // 1C with wrong parity.
    e0 = err_cnt;
    t0 = tog_cnt;
    send_frame(8'h1C, 1'b1, 1'b0, 11);
`ifdef PS2_PARITY_CHECK_EN
    key_exp = 11'h016;
    check("badpar_err", err_cnt - e0, 1);
    check("badpar_tog", tog_cnt - t0, 0);
`else
    key_exp = 11'h41C;
    check("badpar_err", err_cnt - e0, 0);
    check("badpar_tog", tog_cnt - t0, 1);
`endif
    check("badpar_key", int'(ps2_key), int'(key_exp));

    // Bad stop bit: rejected in every build.
    e0 = err_cnt;
    send_frame(8'h33, 1'b0, 1'b1, 11);
    check("badstop_err", err_cnt - e0, 1);
    check("badstop_key", int'(ps2_key), int'(key_exp));

    // Reset mid-frame: partial byte discarded, no error pulse.
    e0 = err_cnt;
    send_frame(8'h5A, 1'b0, 1'b0, 4);
    reset_n = 1'b0;
    wait_clk(5);
    check("midrst_key", int'(ps2_key), 0);
    reset_n = 1'b1;
    wait_clk(5);
    check("midrst_err", err_cnt - e0, 0);
    t0 = tog_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    check("postrst_key", int'(ps2_key), 11'h41C);
    check("postrst_tog", tog_cnt - t0, 1);
    check("postrst_err", err_cnt - e0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
